rename_map: RTL
===============

# rename_map

Register-rename stage of the out-of-order core, directly downstream of the ID/RN pipeline register. Each cycle it accepts at most one decoded instruction and translates its architectural `rs1`/`rs2`/`rd` into physical register tags. It allocates a new physical destination from a circular free list and reports the previous mapping so the ROB can release it at commit. It keeps a speculative RAT and a committed RAT; a flush restores the speculative state from the committed state in one cycle.

## Interface
- `PREG_NUM`, 64, physical register count; legal range 33–128.
- `PREG_W`, 6, tag width, equal to clog2(`PREG_NUM`).
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: pipeline redirect; discards all uncommitted renames.
- `rn_valid` in 1: ID/RN register holds an instruction.
- `rn_inst` in 32: instruction word. `rs1`=[19:15], `rs2`=[24:20], `rd`=[11:7].
- `rn_regwrite` in 1: instruction writes `rd`.
- `rn_stall` out 1: holds the ID/RN register.
- `ds_stall` in 1: dispatch/ROB cannot take an instruction.
- `out_valid` out 1: registered output is a renamed instruction.
- `out_inst` out 32: registered copy of `rn_inst`.
- `out_has_dest` out 1: an allocation occurred.
- `out_prs1`, `out_prs2` out `PREG_W`: source tags.
- `out_prd` out `PREG_W`: new destination tag.
- `out_old_prd` out `PREG_W`: previous mapping of `rd`.
- `cm_en` in 1: ROB commits an instruction that has a destination.
- `cm_rd` in 5: its architectural `rd`.
- `cm_prd` in `PREG_W`: its new tag.
- `cm_old_prd` in `PREG_W`: its old tag, to be freed.

## Operation
- `need` = `rn_regwrite` && `rd`≠0. `x0` always maps to p0 and never allocates.
- `accept` = `rn_valid` & ~`ds_stall` & ~`flush` & (~`need` | `cnt`≠0).
- `rn_stall` = `rn_valid` & ~`accept`. This signal is combinational.
- Source lookup reads the speculative RAT, `sRAT`.
- On `accept` with `need`:
  - pop `fl[head]` as `prd`;
  - read `old_prd` = `sRAT[rd]`;
  - write `sRAT[rd]` <= `prd`.
- Free list: a ring of D = `PREG_NUM`−32 entries, with `head`, `tail` and `chead` (committed head) pointers wrapping modulo D, and an occupancy counter `cnt`.
- On `cm_en`:
  - push `cm_old_prd` at `tail`;
  - advance `chead`;
  - write `cRAT[cm_rd]` <= `cm_prd`.
- `cm_en` takes priority over `flush` and is honoured in the same cycle as a flush.
- On `flush`:
  - `sRAT` <= `cRAT`, including that cycle's commit write;
  - `head` <= `chead` (post-commit value);
  - `cnt` <= D;
  - `out_valid` <= 0.
- Simultaneous pop and push leaves `cnt` unchanged.
- Without bypass, a push to an empty list becomes visible to allocation only in the next cycle.
- Output register:
  - `ds_stall`=1: hold all outputs.
  - `accept`: load the renamed instruction and set `out_valid`=1.
  - Otherwise: clear `out_valid`.
- Reset values:
  - `sRAT[i]` = `cRAT[i]` = i;
  - `fl[i]` = 32+i;
  - `head` = `tail` = `chead` = 0;
  - `cnt` = D;
  - all `out_*` = 0.

## Timing
- Latency is one cycle from `accept` to `out_valid`.
- Back-to-back dependent instructions are handled by the clocked `sRAT` write. The next cycle's lookup sees the new mapping, so no intra-cycle forwarding is needed.
- `flush` takes effect at the clock edge; an instruction is accepted in the following cycle at the earliest.
- When `rst` is asserted mid-operation, all state returns to the reset values immediately.
- `cnt` never exceeds D. A `cm_en` while `cnt`=D is a protocol error and may be flagged by an assertion.

## Configuration
- `RN_COMMIT_BYPASS_EN` defined:
  - when `cnt`=0 and `cm_en`=1, `accept` may proceed;
  - the allocation takes `cm_old_prd` directly as `prd`;
  - `cnt` stays 0 and `head`/`tail` both advance.
- Undefined: `rn_stall` remains asserted for that cycle.

## Test plan
- Reset, then `add x5,x1,x2` with `rn_regwrite`=1 → next cycle: `out_prs1`=1, `out_prs2`=2, `out_prd`=32, `out_old_prd`=5, `out_valid`=1.
- Dependent pair `x5`←…, then `x6`←`x5`+`x5` → second instruction: `out_prs1`=`out_prs2`=32, `out_prd`=33.
- 32 allocations with no commits → `cnt`=0; the 33rd asserts `rn_stall`. Without bypass, `cm_en` with `cm_old_prd`=5 releases the stall one cycle later and the allocation gets `prd`=5. With the macro defined, the allocation is accepted in that same cycle.
- Rename 3 instructions, commit 1, then `flush` → `sRAT` matches `cRAT`, `cnt`=32, and the next allocation returns the tag that followed the committed one.
- `rd`=x0 with `rn_regwrite`=1 → `out_has_dest`=0 and `cnt` unchanged.
- `ds_stall` held for 3 cycles with `rn_valid` → outputs frozen, `rn_stall`=1, no pointer movement.

Source files
------------

// File: rtl/rename_map_if.sv
// rename_map_if: bundles the rename-stage handshake, the renamed-instruction
// output bus and the ROB commit port of rename_map.
//   slave  modport : the rename stage itself (rename_map)
//   master modport : the surrounding pipeline (decode, dispatch, ROB)
// Signals:
//   flush                      redirect, discards uncommitted renames
//   rn_valid/rn_inst/rn_regwrite  instruction from the ID/RN register
//   rn_stall                   hold request back to the ID/RN register
//   ds_stall                   dispatch/ROB back-pressure
//   out_*                      registered renamed instruction
//   cm_en/cm_rd/cm_prd/cm_old_prd  commit of an instruction with a destination
interface rename_map_if #(
    parameter int PREG_W = 6
);
    logic              flush;
    logic              rn_valid;
    logic [31:0]       rn_inst;
    logic              rn_regwrite;
    logic              rn_stall;
    logic              ds_stall;
    logic              out_valid;
    logic [31:0]       out_inst;
    logic              out_has_dest;
    logic [PREG_W-1:0] out_prs1;
    logic [PREG_W-1:0] out_prs2;
    logic [PREG_W-1:0] out_prd;
    logic [PREG_W-1:0] out_old_prd;
    logic              cm_en;
    logic [4:0]        cm_rd;
    logic [PREG_W-1:0] cm_prd;
    logic [PREG_W-1:0] cm_old_prd;

    modport slave (
        input  flush, rn_valid, rn_inst, rn_regwrite, ds_stall,
        input  cm_en, cm_rd, cm_prd, cm_old_prd,
        output rn_stall, out_valid, out_inst, out_has_dest,
        output out_prs1, out_prs2, out_prd, out_old_prd
    );

    modport master (
        output flush, rn_valid, rn_inst, rn_regwrite, ds_stall,
        output cm_en, cm_rd, cm_prd, cm_old_prd,
        input  rn_stall, out_valid, out_inst, out_has_dest,
        input  out_prs1, out_prs2, out_prd, out_old_prd
    );
endinterface

// File: rtl/rename_map.sv
// rename_map: register-rename stage. Translates rs1/rs2/rd of one decoded
// instruction per cycle into physical tags using a speculative RAT, allocates
// destinations from a circular free list, and restores the speculative state
// from the committed RAT on flush.
// Ports:
//   clk   single clock
//   rst   asynchronous active-high reset
//   bus   rename_map_if.slave (handshake, renamed output, commit port)
// Parameters: PREG_NUM physical registers (33..128), PREG_W tag width.
// Optional feature: define RN_COMMIT_BYPASS_EN to let an allocation on an
// empty free list take the tag being released by a same-cycle commit.
module rename_map #(
    parameter int PREG_NUM = 64,
    parameter int PREG_W   = $clog2(PREG_NUM)
) (
    input logic         clk,
    input logic         rst,
    rename_map_if.slave bus
);
    localparam int D     = PREG_NUM - 32;
    localparam int PTR_W = (D > 1) ? $clog2(D) : 1;
    localparam int CNT_W = $clog2(D + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(D - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(D);

    // Ring-pointer increment with wrap at D (D need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == LAST_PTR) begin
            r = '0;
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    logic [PREG_W-1:0] srat_r     [32];
    logic [PREG_W-1:0] crat_r     [32];
    logic [PREG_W-1:0] crat_nxt_s [32];
    logic [PREG_W-1:0] fl_r       [D];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [PTR_W-1:0]  chead_r;
    logic [CNT_W-1:0]  cnt_r;

    logic [4:0]        rd_s;
    logic [4:0]        rs1_s;
    logic [4:0]        rs2_s;
    logic              need_s;
    logic              bypass_s;
    logic              can_alloc_s;
    logic              accept_s;
    logic              pop_s;
    logic              push_s;
    logic [PREG_W-1:0] prd_s;

    // Decode fields, acceptance and the tag chosen for allocation.
    always_comb begin
        rd_s   = bus.rn_inst[11:7];
        rs1_s  = bus.rn_inst[19:15];
        rs2_s  = bus.rn_inst[24:20];
        need_s = bus.rn_regwrite && (rd_s != 5'd0);
`ifdef RN_COMMIT_BYPASS_EN
        bypass_s = (cnt_r == '0) && bus.cm_en;
`else
        bypass_s = 1'b0;
`endif
        can_alloc_s  = (cnt_r != '0) || bypass_s;
        accept_s     = bus.rn_valid && !bus.ds_stall && !bus.flush
                       && (!need_s || can_alloc_s);
        pop_s        = accept_s && need_s;
        push_s       = bus.cm_en;
        bus.rn_stall = bus.rn_valid && !accept_s;
        // On an empty list the only legal source is the tag freed this cycle.
        if (bypass_s) begin
            prd_s = bus.cm_old_prd;
        end else begin
            prd_s = fl_r[head_r];
        end
    end

    // Committed RAT after this cycle's commit; flush copies this into sRAT.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            if (bus.cm_en && (bus.cm_rd == 5'(i)) && (bus.cm_rd != 5'd0)) begin
                crat_nxt_s[i] = bus.cm_prd;
            end else begin
                crat_nxt_s[i] = crat_r[i];
            end
        end
    end

    // RATs, free-list storage, ring pointers and occupancy counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                srat_r[i] <= PREG_W'(i);
                crat_r[i] <= PREG_W'(i);
            end
            for (int i = 0; i < D; i++) begin
                fl_r[i] <= PREG_W'(32 + i);
            end
            head_r  <= '0;
            tail_r  <= '0;
            chead_r <= '0;
            cnt_r   <= FULL_CNT;
        end else begin
            for (int i = 0; i < 32; i++) begin
                crat_r[i] <= crat_nxt_s[i];
            end
            if (bus.flush) begin
                for (int i = 0; i < 32; i++) begin
                    srat_r[i] <= crat_nxt_s[i];
                end
            end else if (pop_s) begin
                srat_r[rd_s] <= prd_s;
            end
            if (push_s) begin
                fl_r[tail_r] <= bus.cm_old_prd;
                tail_r       <= ptr_inc(tail_r);
                chead_r      <= ptr_inc(chead_r);
            end
            if (bus.flush) begin
                // Rewind to the committed head, including a same-cycle commit.
                head_r <= push_s ? ptr_inc(chead_r) : chead_r;
                cnt_r  <= FULL_CNT;
            end else begin
                if (pop_s) begin
                    head_r <= ptr_inc(head_r);
                end
                case ({push_s, pop_s})
                    2'b10: begin
                        // A push onto a full list is a protocol error; saturate.
                        if (cnt_r != FULL_CNT) begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                    default: cnt_r <= cnt_r;
                endcase
            end
        end
    end

    // Output register: renamed instruction toward dispatch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid    <= 1'b0;
            bus.out_inst     <= 32'd0;
            bus.out_has_dest <= 1'b0;
            bus.out_prs1     <= '0;
            bus.out_prs2     <= '0;
            bus.out_prd      <= '0;
            bus.out_old_prd  <= '0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (bus.ds_stall) begin
            bus.out_valid <= bus.out_valid;
        end else if (accept_s) begin
            bus.out_valid    <= 1'b1;
            bus.out_inst     <= bus.rn_inst;
            bus.out_has_dest <= need_s;
            bus.out_prs1     <= srat_r[rs1_s];
            bus.out_prs2     <= srat_r[rs2_s];
            bus.out_prd      <= need_s ? prd_s : '0;
            bus.out_old_prd  <= need_s ? srat_r[rd_s] : '0;
        end else begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule
